// File: rtl/command_executor_pkg.sv
// Shared types and constants for the UART command executor.
package command_executor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_ISSUE,
    S_READ_WAIT,
    S_START,
    S_RESP
  } ctrl_state_e;

  typedef enum logic [1:0] {
    S_SER_IDLE,
    S_RESP_STATUS,
    S_TX_WAIT,
    S_RESP_DATA
  } ser_state_e;

  localparam logic [7:0] ST_WRITE_OK = 8'h00;
  localparam logic [7:0] ST_READ_OK  = 8'h01;
  localparam logic [7:0] ST_ERR_BASE = 8'hE0;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_NO_ADDR = 2'd2;
  localparam logic [1:0] ERR_NO_DATA = 2'd3;

  function automatic logic [7:0] err_status(input logic [1:0] err);
    return ST_ERR_BASE | {6'd0, err};
  endfunction

endpackage

// File: rtl/command_executor_resp_serializer.sv
// Sends a status byte plus optional LSB-first data bytes to uart_tx, with a per-byte timeout.
module command_executor_resp_serializer
  import command_executor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TX_TIMEOUT = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [7:0]            i_status,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_is_read,
  input  logic                  i_tx_busy,
  input  logic                  i_tx_done,
  output logic [7:0]            o_tx_byte,
  output logic                  o_tx_start,
  output logic                  o_tx_timeout,
  output logic                  o_done_c
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(NBYTES + 1);
  localparam int unsigned CNT_W  = $clog2(TX_TIMEOUT + 1);

  ser_state_e            state_q, state_d;
  logic [7:0]            status_q, status_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  is_read_q, is_read_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_start_q, tx_start_d;
  logic                  timeout_q, timeout_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_SER_IDLE;
      status_q   <= '0;
      shift_q    <= '0;
      is_read_q  <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      shift_q    <= shift_d;
      is_read_q  <= is_read_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
    end
  end

  // Idle with a free transmitter launches the status byte straight away to keep latency minimal.
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    shift_d    = shift_q;
    is_read_d  = is_read_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    timeout_d  = timeout_q;
    o_done_c   = 1'b0;
    case (state_q)
      S_SER_IDLE: begin
        if (i_start) begin
          status_d  = i_status;
          shift_d   = i_data;
          is_read_d = i_is_read;
          idx_d     = '0;
          if (!i_tx_busy) begin
            tx_byte_d  = i_status;
            tx_start_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_TX_WAIT;
          end else begin
            state_d = S_RESP_STATUS;
          end
        end
      end
      S_RESP_STATUS: begin
        if (!i_tx_busy) begin
          tx_byte_d  = status_q;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (i_tx_done) begin
          if (is_read_q && (idx_q < IDX_W'(NBYTES))) begin
            state_d = S_RESP_DATA;
          end else begin
            state_d  = S_SER_IDLE;
            o_done_c = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TX_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_SER_IDLE;
          o_done_c  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP_DATA: begin
        if (!i_tx_busy) begin
          tx_byte_d  = shift_q[7:0];
          shift_d    = shift_q >> 8;
          idx_d      = idx_q + IDX_W'(1);
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_TX_WAIT;
        end
      end
      default: state_d = S_SER_IDLE;
    endcase
  end

  assign o_tx_byte    = tx_byte_q;
  assign o_tx_start   = tx_start_q;
  assign o_tx_timeout = timeout_q;

endmodule

// File: rtl/command_executor.sv
// Turns one decoded UART command into a memory access and hands the response to the serializer.
module command_executor
  import command_executor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 15,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned MEM_READ_LATENCY = 1,
  parameter int unsigned TX_TIMEOUT       = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_cmd_done,
  input  logic                  i_cmd_readwrite,
  input  logic [ADDR_WIDTH-1:0] i_cmd_address,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  input  logic [1:0]            i_cmd_error,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [7:0]            o_tx_byte,
  output logic                  o_tx_start,
  input  logic                  i_tx_busy,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_tx_timeout
);

  localparam int unsigned LAT_W = 3;

  ctrl_state_e           state_q, state_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  ser_start_c;
  logic [7:0]            ser_status_c;
  logic                  ser_done_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= ERR_NONE;
      rdata_q   <= '0;
      lat_q     <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      lat_q     <= lat_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Memory strobes and busy are decoded from the next state so they line up with the state register.
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    lat_d        = lat_q;
    ser_start_c  = 1'b0;
    ser_status_c = ST_WRITE_OK;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_done) begin
          rw_d    = i_cmd_readwrite;
          addr_d  = i_cmd_address;
          wdata_d = i_cmd_data;
          err_d   = i_cmd_error;
          if (i_cmd_error != ERR_NONE) state_d = S_START;
          else if (i_cmd_readwrite)    state_d = S_READ_ISSUE;
          else                         state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ser_start_c  = 1'b1;
        ser_status_c = ST_WRITE_OK;
        state_d      = S_RESP;
      end
      S_READ_ISSUE: begin
        lat_d   = '0;
        state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (lat_q == LAT_W'(MEM_READ_LATENCY - 1)) begin
          rdata_d = i_mem_rdata;
          state_d = S_START;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_START: begin
        ser_start_c  = 1'b1;
        ser_status_c = (err_q != ERR_NONE) ? err_status(err_q) : ST_READ_OK;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (ser_done_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    overrun_d = overrun_q | (i_cmd_done && (state_q != S_IDLE));
    mem_en_d  = (state_d == S_WRITE) || (state_d == S_READ_ISSUE);
    mem_we_d  = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
  end

  command_executor_resp_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .TX_TIMEOUT (TX_TIMEOUT)
  ) u_resp_serializer (
    .clock        (clock),
    .reset        (reset),
    .i_start      (ser_start_c),
    .i_status     (ser_status_c),
    .i_data       (rdata_q),
    .i_is_read    (rw_q && (err_q == ERR_NONE)),
    .i_tx_busy    (i_tx_busy),
    .i_tx_done    (i_tx_done),
    .o_tx_byte    (o_tx_byte),
    .o_tx_start   (o_tx_start),
    .o_tx_timeout (o_tx_timeout),
    .o_done_c     (ser_done_c)
  );

  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = busy_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_command_executor.sv
// Directed bench for command_executor with a latency-2 memory model and a simple uart_tx model.
module tb_command_executor;

  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned TMO = 50;

  logic          clock;
  logic          reset;
  logic          i_cmd_done;
  logic          i_cmd_readwrite;
  logic [AW-1:0] i_cmd_address;
  logic [DW-1:0] i_cmd_data;
  logic [1:0]    i_cmd_error;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic [7:0]    o_tx_byte;
  logic          o_tx_start;
  logic          i_tx_busy;
  logic          i_tx_done;
  logic          o_busy;
  logic          o_overrun;
  logic          o_tx_timeout;

  command_executor #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .MEM_READ_LATENCY (LAT),
    .TX_TIMEOUT       (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i_cmd_done      (i_cmd_done),
    .i_cmd_readwrite (i_cmd_readwrite),
    .i_cmd_address   (i_cmd_address),
    .i_cmd_data      (i_cmd_data),
    .i_cmd_error     (i_cmd_error),
    .o_mem_en        (o_mem_en),
    .o_mem_we        (o_mem_we),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_rdata     (i_mem_rdata),
    .o_tx_byte       (o_tx_byte),
    .o_tx_start      (o_tx_start),
    .i_tx_busy       (i_tx_busy),
    .i_tx_done       (i_tx_done),
    .o_busy          (o_busy),
    .o_overrun       (o_overrun),
    .o_tx_timeout    (o_tx_timeout)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          c0;
  int          end_cyc;
  int          tx_first_cyc;
  logic        tx_stall;
  logic [7:0]  txq[$];
  acc_t        accq[$];
  logic [DW-1:0] mem[int];
  logic [DW-1:0] p1, p2;
  logic [7:0]  exp_rd[5];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // uart_tx model: busy for three cycles after each start, then a done pulse unless stalled.
  initial begin
    i_tx_busy = 1'b0;
    i_tx_done = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (o_tx_start) begin
        if (txq.size() == 0) tx_first_cyc = cyc;
        txq.push_back(o_tx_byte);
        i_tx_busy = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        i_tx_busy = 1'b0;
        i_tx_done = !tx_stall;
        @(posedge clock); #1;
        i_tx_done = 1'b0;
      end
    end
  end

  // Memory model: read data valid exactly LAT cycles after the enable cycle.
  initial begin
    p1 = '0;
    p2 = '0;
    i_mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      i_mem_rdata = p2;
      p2 = p1;
      p1 = '0;
      if (o_mem_en) begin
        accq.push_back({o_mem_we, o_mem_addr, o_mem_wdata});
        if (o_mem_we) mem[int'(o_mem_addr)] = o_mem_wdata;
        else if (mem.exists(int'(o_mem_addr))) p1 = mem[int'(o_mem_addr)];
      end
    end
  end

  task automatic pulse_cmd(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] e);
    @(posedge clock); #1;
    c0 = cyc;
    i_cmd_done      = 1'b1;
    i_cmd_readwrite = rw;
    i_cmd_address   = a;
    i_cmd_data      = d;
    i_cmd_error     = e;
    @(posedge clock); #1;
    i_cmd_done = 1'b0;
  endtask

  task automatic issue_cmd(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] e);
    txq.delete();
    accq.delete();
    tx_first_cyc = -1;
    pulse_cmd(rw, a, d, e);
    check("busy_set", 64'(o_busy), 64'd1);
  endtask

  task automatic wait_idle();
    end_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      if (!o_busy) begin
        end_cyc = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    check("busy_release", 64'(o_busy), 64'd0);
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic check_read_frame(input string tag);
    check({tag, "_len"}, 64'(txq.size()), 64'd5);
    for (int i = 0; i < 5 && i < txq.size(); i++) check({tag, "_byte"}, 64'(txq[i]), 64'(exp_rd[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_rd = '{8'h01, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    reset = 1'b0;
    tx_stall = 1'b0;
    tx_first_cyc = -1;
    i_cmd_done = 1'b0;
    i_cmd_readwrite = 1'b0;
    i_cmd_address = '0;
    i_cmd_data = '0;
    i_cmd_error = 2'd0;
    mem[5] = 32'hCAFEF00D;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 64'({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_tx_byte,
                                o_tx_start, o_busy, o_overrun, o_tx_timeout}), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle_busy", 64'(o_busy), 64'd0);

    // Write
    issue_cmd(1'b0, 15'h1234, 32'hDEADBEEF, 2'd0);
    wait_idle();
    check("wr_acc_count", 64'(accq.size()), 64'd1);
    if (accq.size() > 0) check("wr_acc", 64'(accq[0]), 64'({1'b1, 15'h1234, 32'hDEADBEEF}));
    check("wr_tx_len", 64'(txq.size()), 64'd1);
    if (txq.size() > 0) check("wr_status", 64'(txq[0]), 64'h00);
    check("wr_latency", 64'(tx_first_cyc - c0), 64'd2);

    // Read
    issue_cmd(1'b1, 15'h0005, 32'h0, 2'd0);
    wait_idle();
    check("rd_acc_count", 64'(accq.size()), 64'd1);
    if (accq.size() > 0) check("rd_acc", 64'({accq[0].we, accq[0].addr}), 64'({1'b0, 15'h0005}));
    check_read_frame("rd");
    check("rd_latency", 64'(tx_first_cyc - c0), 64'(2 + LAT + 1));

    // Decoder error: no memory access, status only
    issue_cmd(1'b1, 15'h0005, 32'h0, 2'd2);
    wait_idle();
    check("err_acc_count", 64'(accq.size()), 64'd0);
    check("err_tx_len", 64'(txq.size()), 64'd1);
    if (txq.size() > 0) check("err_status", 64'(txq[0]), 64'hE2);

    // Overrun during a read response
    check("ovr_clear", 64'(o_overrun), 64'd0);
    issue_cmd(1'b1, 15'h0005, 32'h0, 2'd0);
    for (int i = 0; i < 100 && txq.size() < 1; i++) begin
      @(posedge clock); #2;
    end
    pulse_cmd(1'b0, 15'h0077, 32'h11111111, 2'd0);
    check("ovr_flag", 64'(o_overrun), 64'd1);
    wait_idle();
    check_read_frame("ovr");
    check("ovr_acc_count", 64'(accq.size()), 64'd1);
    check("ovr_no_write", 64'(mem.exists(32'h77)), 64'd0);

    // Stalled transmitter
    tx_stall = 1'b1;
    issue_cmd(1'b0, 15'h0042, 32'h00000055, 2'd0);
    wait_idle();
    check("tmo_flag", 64'(o_tx_timeout), 64'd1);
    check("tmo_cycles", 64'(end_cyc - tx_first_cyc), 64'(TMO));
    check("tmo_tx_len", 64'(txq.size()), 64'd1);
    tx_stall = 1'b0;
    issue_cmd(1'b0, 15'h0043, 32'h00000066, 2'd0);
    wait_idle();
    check("post_tmo_tx_len", 64'(txq.size()), 64'd1);
    if (txq.size() > 0) check("post_tmo_status", 64'(txq[0]), 64'h00);
    check("post_tmo_acc", 64'(accq.size()), 64'd1);

    // Reset in the middle of a read frame, after the second data byte starts
    issue_cmd(1'b1, 15'h0005, 32'h0, 2'd0);
    for (int i = 0; i < 200 && txq.size() < 3; i++) begin
      @(posedge clock); #2;
    end
    check("rst_mid_bytes", 64'(txq.size()), 64'd3);
    reset = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_tx_byte,
                                  o_tx_start, o_busy, o_overrun, o_tx_timeout}), 64'd0);
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("rst_no_more_tx", 64'(txq.size()), 64'd3);
    check("rst_idle", 64'(o_busy), 64'd0);
    issue_cmd(1'b1, 15'h0005, 32'h0, 2'd0);
    wait_idle();
    check_read_frame("rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/command_executor.md
Name: command_executor

Overview:
- Sequences each decoded UART command into a single-port memory access, then returns a response frame over the UART transmitter.
- Sits between the UART command decoder (upstream) and the memory plus uart_tx (downstream).
- One command in flight at a time. Commands arriving while busy are dropped and flagged.

Parameters:
- ADDR_WIDTH, 15, memory word address width; matches the decoder address field.
- DATA_WIDTH, 32, memory word width; must be a multiple of 8.
- MEM_READ_LATENCY, 1, cycles from o_mem_en (read) to a valid i_mem_rdata; legal range 1..4.
- TX_TIMEOUT, 100000, maximum cycles to wait for i_tx_done per byte before aborting.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active low
- i_cmd_done  in  1  one-cycle pulse: decoded command valid
- i_cmd_readwrite  in  1  1 = read, 0 = write; valid with i_cmd_done
- i_cmd_address  in  ADDR_WIDTH  word address; valid with i_cmd_done
- i_cmd_data  in  DATA_WIDTH  write data; valid with i_cmd_done
- i_cmd_error  in  2  decoder error code; 0 = none, 1 = bad command, 2 = no address, 3 = no data
- o_mem_en  out  1  memory enable, one-cycle pulse
- o_mem_we  out  1  write enable, qualified by o_mem_en
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data
- o_tx_byte  out  8  byte to transmit
- o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_byte
- i_tx_busy  in  1  transmitter busy
- i_tx_done  in  1  one-cycle pulse: byte fully sent
- o_busy  out  1  high from command capture until return to S_IDLE
- o_overrun  out  1  sticky: a command arrived while busy
- o_tx_timeout  out  1  sticky: a transmit byte timed out

Behaviour:
- Reset values: all outputs 0. State = S_IDLE. Internal counters 0. Sticky flags are cleared only by reset.
- Reset mid-operation: abandons the access and the frame immediately. No further o_tx_start or o_mem_en is issued.
- Capture: in S_IDLE, when i_cmd_done is high, latch readwrite, address, data and error, set o_busy next cycle.
  - If error != 0: go to S_RESP_STATUS with status 0xE0 | error.
  - Else if read: go to S_READ_ISSUE.
  - Else: go to S_WRITE.
- Overrun: i_cmd_done high while not in S_IDLE sets o_overrun and is otherwise ignored. i_cmd_done in the same cycle the FSM enters S_IDLE is also ignored.
- S_WRITE:
  - One cycle: o_mem_en = 1, o_mem_we = 1, o_mem_addr/o_mem_wdata = latched values.
  - Status = 0x00; go to S_RESP_STATUS.
- S_READ_ISSUE:
  - One cycle: o_mem_en = 1, o_mem_we = 0.
  - Go to S_READ_WAIT.
- S_READ_WAIT:
  - Count MEM_READ_LATENCY cycles, then latch i_mem_rdata into the response shift register.
  - Status = 0x01; go to S_RESP_STATUS.
- S_RESP_STATUS:
  - When i_tx_busy is low: drive o_tx_byte = status, pulse o_tx_start for one cycle.
  - Go to S_TX_WAIT with byte index 0.
- S_TX_WAIT:
  - Wait for the i_tx_done pulse, incrementing the timeout counter.
  - On i_tx_done: if the command is a read and index < DATA_WIDTH/8, go to S_RESP_DATA; otherwise go to S_IDLE with o_busy = 0.
  - If the counter reaches TX_TIMEOUT: set o_tx_timeout, go to S_IDLE.
  - The counter clears on every new o_tx_start.
- S_RESP_DATA:
  - When i_tx_busy is low: send data byte [8*index +: 8] (LSB first), pulse o_tx_start, increment index.
  - Return to S_TX_WAIT.
- Frame formats:
  - Read: 1 status byte + DATA_WIDTH/8 data bytes.
  - Write or error: status byte only.
- Minimum latency: i_cmd_done to first o_tx_start = 2 cycles (write), 2 + MEM_READ_LATENCY + 1 cycles (read), when i_tx_busy is low.
- Memory is never accessed for error commands.
- Address and data are passed through unmodified; no width arithmetic beyond byte slicing.

Decomposition:
- Shared package holds:
  - state encodings;
  - status constants ST_WRITE_OK = 0x00, ST_READ_OK = 0x01, ST_ERR_BASE = 0xE0;
  - decoder error codes 0..3.
- One natural sub-module: resp_serializer (S_RESP_STATUS/S_RESP_DATA/S_TX_WAIT, shift register, timeout counter), handed a start pulse plus status/data/length.

Test Plan:
- Write: i_cmd_done with rw = 0, addr 0x1234, data 0xDEADBEEF -> one o_mem_en/o_mem_we pulse carrying those values; TX sends 0x00 only; o_busy returns to 0.
- Read with MEM_READ_LATENCY = 2, memory returning 0xCAFEF00D at 0x0005 -> o_mem_en with we = 0 at addr 0x0005; TX sends 0x01, 0x0D, 0xF0, 0xFE, 0xCA.
- Decoder error: i_cmd_error = 2 -> no o_mem_en; TX sends 0xE2 only.
- Overrun: second i_cmd_done during a read response -> o_overrun = 1, first frame completes unchanged, second command has no effect.
- Stalled TX (i_tx_done never pulses, TX_TIMEOUT = 50) -> o_tx_timeout set after 50 cycles, FSM in S_IDLE, next command processed normally.
- Reset asserted mid-read after the 2nd data byte -> all outputs 0 immediately, no further o_tx_start; a new read after release produces a full 5-byte frame.
